irig_width_encode: RTL
======================

# irig_width_encode

IRIG-B (B00x, DC level-shift) width-encoding transmitter. It takes BCD time-of-year, year and straight-binary-seconds (SBS) fields from host logic and emits one 100-bit frame per second on `irigb`. It drives the on-time reference edge and a one-cycle `pps` aligned to it. It sits in the timing output path and is the transmit counterpart of `irig_width_decode`, so the two can be looped back.

## Interface
- `CYCLES_BIT`, 100000: clk cycles per IRIG bit (10 MHz clk, 100 bit/s).
- `CYCLES_ZERO`, 20000: high time of a logic 0 (2 ms).
- `CYCLES_ONE`, 50000: high time of a logic 1 (5 ms).
- `CYCLES_MARK`, 80000: high time of a marker (8 ms).
- `clk`  in  1  system clock, 10 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  transmit enable; sampled only at frame boundaries.
- `time_wr`  in  1  strobe that latches all time inputs into the hold registers.
- `sec_bcd`  in  7  seconds, BCD (tens[6:4], units[3:0]).
- `min_bcd`  in  7  minutes, BCD.
- `hour_bcd`  in  6  hours, BCD (tens[5:4]).
- `day_bcd`  in  10  day of year, BCD (hundreds[9:8]).
- `year_bcd`  in  8  two-digit year, BCD.
- `sbs`  in  17  straight binary seconds of day.
- `irigb`  out  1  encoded IRIG-B level, registered.
- `pps`  out  1  one-cycle pulse on the first high cycle of Pr.
- `frame_stale`  out  1  high for the whole frame when it was loaded without a new `time_wr`.
- `busy`  out  1  high while a frame is in progress.

## Operation
- States: IDLE and RUN. IDLE→RUN when `enable`=1; that cycle is a *load cycle*. In RUN, `cnt` counts 0..CYCLES_BIT-1 and `bit_idx` counts 0..99.
- The last cycle of bit 99 is also a load cycle. If `enable`=1 there, RUN continues with `bit_idx`=0. Otherwise go to IDLE. Deasserting `enable` mid-frame never truncates a frame.
- Load cycle:
  - Copy hold registers into frame registers.
  - `frame_stale` <= !pending.
  - Clear pending.
- `time_wr` latches inputs into the hold registers and sets pending. If `time_wr` coincides with a load cycle, the load uses the pre-write hold values and pending ends set, so the write goes to the next frame.
- Symbol per bit:
  - MARK at 0 (Pr) and at 9, 19, …, 99 (P1–P0).
  - BCD fields LSB first: sec units 1-4, sec tens 6-8; min 10-13 / 15-17; hour 20-23 / 25-26; day 30-33 / 35-38 / 40-41; year 50-53 / 55-58.
  - SBS[8:0] at 80-88, SBS[16:9] at 90-97.
  - All other bits are ZERO.
- High time per bit: `cnt` < width(symbol). `irigb` is low for the rest of the bit.
- BCD digits are not range-checked; they are transmitted as given.
- Reset values:
  - `irigb`, `pps`, `frame_stale`, `busy` = 0.
  - State IDLE, counters 0.
  - Hold and frame registers 0, pending 0.
- Reset mid-frame drops `irigb` low on the next cycle with no partial completion.

## Timing
- `irigb`, `pps`, `busy` are registered. The first high cycle of Pr is the cycle after the load cycle; `pps` is asserted in that same cycle.
- Frame period is exactly 100·CYCLES_BIT cycles. Back-to-back frames have no gap: bit 99 ends and bit 0 rises on the next cycle.
- A MARK spans exactly CYCLES_MARK high cycles, then CYCLES_BIT−CYCLES_MARK low cycles. ONE and ZERO follow the same rule with their widths.
- `busy` rises with the first Pr high cycle. It falls the cycle after the last cycle of bit 99 when the frame ends in IDLE.
- Counter widths: `cnt` is 17 bits (covers CYCLES_BIT−1) and `bit_idx` is 7 bits. The parameter constraint CYCLES_ZERO < CYCLES_ONE < CYCLES_MARK < CYCLES_BIT is checked by an elaboration assertion.

## Structure
- Package `irig_pkg` holds:
  - symbol enum {SYM_ZERO, SYM_ONE, SYM_MARK} (2 bits);
  - default cycle constants;
  - bit-position constants for every field and marker (shared with decoder-side logic).
- Sub-module `irig_frame_map` (combinational) maps frame registers plus `bit_idx` to a symbol. The top level holds the FSM, counters, hold/frame registers and the width compare.

## Test plan
Use the scaled parameters BIT=100, ZERO=20, ONE=50, MARK=80 throughout.
- Reset, `enable`=1 → `pps` one cycle after the load cycle; `irigb` high for exactly 80 cycles, then 20 low; bit 1 high 20 cycles (time=0).
- `time_wr` with sec=0x59, min=0x34, hour=0x23, day=0x365, year=0x24, sbs=86399 → captured 100-symbol frame matches the bit map exactly; `frame_stale`=0. The following frame without a write repeats the same values with `frame_stale`=1.
- `time_wr` asserted on a load cycle → current frame carries the old values and the next frame carries the new ones.
- `enable` dropped at bit 40 → frame completes all 100 bits, `busy` falls, `irigb` stays low; re-enable → new Pr with `pps`.
- `rst` at bit 57 mid-high → `irigb`=0 next cycle and all outputs at reset values; restart gives a clean frame with time=0.
- Loopback into `irig_width_decode` over 3 frames → 11 marks per frame, and consecutive `pps` are exactly 10000 cycles apart.

Source files
------------

// File: rtl/irig_pkg.sv
// Shared IRIG-B definitions: symbol encoding, default timing and frame bit map.
package irig_pkg;

  // Symbol carried by one IRIG bit slot; the high time is what distinguishes them.
  typedef enum logic [1:0] {
    SYM_ZERO = 2'd0,
    SYM_ONE  = 2'd1,
    SYM_MARK = 2'd2
  } irig_sym_e;

  // Transmitter control state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } enc_state_e;

  // Default timing for a 10 MHz clock at 100 bit/s.
  localparam int DEF_CYCLES_BIT  = 100000;
  localparam int DEF_CYCLES_ZERO = 20000;
  localparam int DEF_CYCLES_ONE  = 50000;
  localparam int DEF_CYCLES_MARK = 80000;

  localparam int CNT_W      = 17;
  localparam int BIT_W      = 7;
  localparam int FRAME_BITS = 100;
  localparam int LAST_BIT   = FRAME_BITS - 1;

  // Markers: Pr at 0, then P1..P9, P0 at 9, 19, ... 99.
  localparam int POS_PR       = 0;
  localparam int MARK_FIRST   = 9;
  localparam int MARK_STRIDE  = 10;

  // First bit of each field; every field is sent LSB first.
  localparam int POS_SEC_UNITS  = 1;
  localparam int POS_SEC_TENS   = 6;
  localparam int POS_MIN_UNITS  = 10;
  localparam int POS_MIN_TENS   = 15;
  localparam int POS_HOUR_UNITS = 20;
  localparam int POS_HOUR_TENS  = 25;
  localparam int POS_DAY_UNITS  = 30;
  localparam int POS_DAY_TENS   = 35;
  localparam int POS_DAY_HUNDS  = 40;
  localparam int POS_YEAR_UNITS = 50;
  localparam int POS_YEAR_TENS  = 55;
  localparam int POS_SBS_LO     = 80;
  localparam int POS_SBS_HI     = 90;

  // Time fields as held by the transmitter and the receiver.
  typedef struct packed {
    logic [6:0]  sec;
    logic [6:0]  min;
    logic [5:0]  hour;
    logic [9:0]  day;
    logic [7:0]  year;
    logic [16:0] sbs;
  } irig_time_t;

  // True for the 11 marker slots of a frame.
  function automatic logic is_marker(input logic [BIT_W-1:0] idx);
    return (idx == BIT_W'(POS_PR)) ||
           ((idx <= BIT_W'(LAST_BIT)) &&
            ((idx % BIT_W'(MARK_STRIDE)) == BIT_W'(MARK_FIRST)));
  endfunction

endpackage

// File: rtl/irig_frame_map.sv
// Combinational map from frame time fields and bit index to the IRIG symbol.
module irig_frame_map
  import irig_pkg::*;
(
  input  irig_time_t       frame_i,
  input  logic [BIT_W-1:0] bit_idx_i,
  output irig_sym_e        sym_o
);

  logic [127:0] one_vec;

  // Scatter every field to its slot, then pick the slot for this bit.
  always_comb begin
    one_vec = '0;
    one_vec[POS_SEC_UNITS  +: 4] = frame_i.sec[3:0];
    one_vec[POS_SEC_TENS   +: 3] = frame_i.sec[6:4];
    one_vec[POS_MIN_UNITS  +: 4] = frame_i.min[3:0];
    one_vec[POS_MIN_TENS   +: 3] = frame_i.min[6:4];
    one_vec[POS_HOUR_UNITS +: 4] = frame_i.hour[3:0];
    one_vec[POS_HOUR_TENS  +: 2] = frame_i.hour[5:4];
    one_vec[POS_DAY_UNITS  +: 4] = frame_i.day[3:0];
    one_vec[POS_DAY_TENS   +: 4] = frame_i.day[7:4];
    one_vec[POS_DAY_HUNDS  +: 2] = frame_i.day[9:8];
    one_vec[POS_YEAR_UNITS +: 4] = frame_i.year[3:0];
    one_vec[POS_YEAR_TENS  +: 4] = frame_i.year[7:4];
    one_vec[POS_SBS_LO     +: 9] = frame_i.sbs[8:0];
    one_vec[POS_SBS_HI     +: 8] = frame_i.sbs[16:9];

    if (is_marker(bit_idx_i)) begin
      sym_o = SYM_MARK;
    end else if (one_vec[bit_idx_i]) begin
      sym_o = SYM_ONE;
    end else begin
      sym_o = SYM_ZERO;
    end
  end

endmodule

// File: rtl/irig_width_encode.sv
// IRIG-B width-encoding transmitter: one 100-bit frame per second with pps on Pr.
module irig_width_encode
  import irig_pkg::*;
#(
  parameter int CYCLES_BIT  = DEF_CYCLES_BIT,
  parameter int CYCLES_ZERO = DEF_CYCLES_ZERO,
  parameter int CYCLES_ONE  = DEF_CYCLES_ONE,
  parameter int CYCLES_MARK = DEF_CYCLES_MARK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        time_wr,
  input  logic [6:0]  sec_bcd,
  input  logic [6:0]  min_bcd,
  input  logic [5:0]  hour_bcd,
  input  logic [9:0]  day_bcd,
  input  logic [7:0]  year_bcd,
  input  logic [16:0] sbs,
  output logic        irigb,
  output logic        pps,
  output logic        frame_stale,
  output logic        busy,
  output enc_state_e  dbg_state_o
);

  if (!((CYCLES_ZERO < CYCLES_ONE) && (CYCLES_ONE < CYCLES_MARK) &&
        (CYCLES_MARK < CYCLES_BIT) && (CYCLES_BIT <= (1 << CNT_W)))) begin : g_param_check
    $error("irig_width_encode: need CYCLES_ZERO < CYCLES_ONE < CYCLES_MARK < CYCLES_BIT <= 2**17");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(LAST_BIT);
  localparam logic [CNT_W-1:0] W_ZERO   = CNT_W'(CYCLES_ZERO);
  localparam logic [CNT_W-1:0] W_ONE    = CNT_W'(CYCLES_ONE);
  localparam logic [CNT_W-1:0] W_MARK   = CNT_W'(CYCLES_MARK);

  enc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  irig_time_t       hold_q, hold_d;
  irig_time_t       frame_q, frame_d;
  logic             pending_q, pending_d;
  logic             stale_q, stale_d;
  logic             busy_q, busy_d;
  logic             pps_q, pps_d;
  logic             irigb_q, irigb_d;
  logic             load;
  irig_sym_e        sym;
  logic [CNT_W-1:0] width;

  // The counters name the slot position that irigb will show after the next edge,
  // so the map looks at the next bit index and the current frame registers.
  // A load always lands on bit 0 (a marker), so the stale frame_q is harmless there.
  irig_frame_map u_map (
    .frame_i   (frame_q),
    .bit_idx_i (bit_d),
    .sym_o     (sym)
  );

  // Next-state: FSM, slot counters, frame load and host write capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    hold_d    = hold_q;
    frame_d   = frame_q;
    pending_d = pending_q;
    stale_d   = stale_q;
    busy_d    = busy_q;
    pps_d     = 1'b0;
    load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        busy_d = 1'b0;
        if (enable) begin
          load    = 1'b1;
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (enable) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    if (load) begin
      frame_d   = hold_q;
      stale_d   = ~pending_q;
      pending_d = 1'b0;
      pps_d     = 1'b1;
    end

    // A write on a load cycle misses this frame (frame_d took the old hold_q)
    // and stays pending for the next one.
    if (time_wr) begin
      hold_d.sec  = sec_bcd;
      hold_d.min  = min_bcd;
      hold_d.hour = hour_bcd;
      hold_d.day  = day_bcd;
      hold_d.year = year_bcd;
      hold_d.sbs  = sbs;
      pending_d   = 1'b1;
    end
  end

  // Width compare: high while the slot position is below the symbol's high time.
  always_comb begin
    case (sym)
      SYM_MARK: width = W_MARK;
      SYM_ONE:  width = W_ONE;
      default:  width = W_ZERO;
    endcase
    irigb_d = (state_d == ST_RUN) && (cnt_d < width);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      hold_q    <= '0;
      frame_q   <= '0;
      pending_q <= 1'b0;
      stale_q   <= 1'b0;
      busy_q    <= 1'b0;
      pps_q     <= 1'b0;
      irigb_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      hold_q    <= hold_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      stale_q   <= stale_d;
      busy_q    <= busy_d;
      pps_q     <= pps_d;
      irigb_q   <= irigb_d;
    end
  end

  assign irigb       = irigb_q;
  assign pps         = pps_q;
  assign frame_stale = stale_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule
